// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mem_access_unit_pkg
// Brief    : Shared CPU defines for the M-stage memory access unit: opcodes,
//            transfer size codes and memory FSM state encodings.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package mem_access_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } memState_t;

  // Transfer size implied by a load/store opcode; unknown opcodes act as words.
  function automatic logic [1:0] opSize(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: opSize = SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: opSize = SIZE_HALF;
      default:              opSize = SIZE_WORD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_align.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mem_align
// Brief    : Purely combinational store lane steering (strobes/replicated
//            data) and load byte/half selection with sign/zero extension.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mem_align
  import mem_access_unit_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_addrLo,
  input  logic [31:0] i_rtValue,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  input  logic [5:0]  i_ldOp,
  input  logic [1:0]  i_ldOff,
  input  logic [31:0] i_rawData,
  output logic [31:0] o_ldData
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store side: enable the addressed lanes and replicate data across the word.
  always_comb begin
    o_wstrb = 4'hF;
    o_wdata = i_rtValue;
    case (opSize(i_op))
      SIZE_BYTE: begin
        o_wstrb = 4'b0001 << i_addrLo;
        o_wdata = {4{i_rtValue[7:0]}};
      end
      SIZE_HALF: begin
        o_wstrb = i_addrLo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_rtValue[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: pick the addressed lane and extend according to the opcode.
  always_comb begin
    w_byte   = i_rawData[{i_ldOff, 3'b000} +: 8];
    w_half   = i_ldOff[1] ? i_rawData[31:16] : i_rawData[15:0];
    o_ldData = i_rawData;
    case (i_ldOp)
      OP_LB:   o_ldData = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_ldData = {24'd0, w_byte};
      OP_LH:   o_ldData = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_ldData = {16'd0, w_half};
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mem_access_unit
// Brief    : M-stage load/store unit: alignment exceptions, request handshake
//            (addr_ok/data_ok), flush draining and pipeline stall generation.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int KSEG1_UNCACHED = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_readM,
  input  logic        mem_writeM,
  input  logic [31:0] instrM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] rt_valueM,
  input  logic        except_blockM,
  input  logic        flushM,
  input  logic        stall_ext,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  output logic        data_uncached,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] rdataM,
  output logic        adelM,
  output logic        adesM,
  output logic [31:0] badvaddrM,
  output logic        mem_stall
);

  memState_t   r_state;
  logic [31:0] r_addr;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [5:0]  r_op;
  logic        r_isLoad;
  logic        r_flushSeen;
  logic [31:0] r_held;

  logic [5:0]  w_op;
  logic [1:0]  w_size;
  logic        w_misalign;
  logic        w_adelRaw;
  logic        w_adesRaw;
  logic        w_issuable;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_ldData;
  logic        w_inReq;
  logic [31:0] w_reqAddr;
  logic        w_unusedInstr;

  assign w_op          = instrM[31:26];
  assign w_unusedInstr = ^instrM[25:0];
  assign w_size        = opSize(w_op);
  assign w_misalign    = ((w_size == SIZE_HALF) & aluoutM[0]) |
                         ((w_size == SIZE_WORD) & (aluoutM[1:0] != 2'b00));
  assign w_adelRaw     = mem_readM & w_misalign;
  assign w_adesRaw     = mem_writeM & w_misalign;
  assign w_issuable    = (mem_readM | mem_writeM) & ~except_blockM &
                         ~w_adelRaw & ~w_adesRaw & ~flushM;

  mem_align u_align (
    .i_op      (w_op),
    .i_addrLo  (aluoutM[1:0]),
    .i_rtValue (rt_valueM),
    .o_wstrb   (w_wstrb),
    .o_wdata   (w_wdata),
    .i_ldOp    (r_op),
    .i_ldOff   (r_addr[1:0]),
    .i_rawData (data_rdata),
    .o_ldData  (w_ldData)
  );

  // Request fields come straight from M on the issue cycle, then from the latch
  // so a pending request cannot change even if M is flushed underneath it.
  assign w_inReq   = (r_state == ST_REQ);
  assign w_reqAddr = w_inReq ? r_addr : aluoutM;

  assign data_req   = rst & (((r_state == ST_IDLE) & w_issuable) | w_inReq);
  assign data_addr  = data_req ? w_reqAddr : 32'd0;
  assign data_wr    = data_req & (w_inReq ? r_wr : mem_writeM);
  assign data_size  = data_req ? (w_inReq ? r_size : w_size) : 2'd0;
  assign data_wdata = data_req ? (w_inReq ? r_wdata : w_wdata) : 32'd0;
  assign data_wstrb = data_req ? (w_inReq ? r_wstrb : w_wstrb) : 4'd0;

  generate
    if (KSEG1_UNCACHED != 0) begin : g_kseg1Uncached
      assign data_uncached = data_req & (w_reqAddr[31:29] == 3'b101);
    end else begin : g_allCached
      assign data_uncached = 1'b0;
    end
  endgenerate

  assign adelM     = rst & w_adelRaw;
  assign adesM     = rst & w_adesRaw;
  assign badvaddrM = (adelM | adesM) ? aluoutM : 32'd0;

  assign rdataM = !rst                                               ? 32'd0 :
                  ((r_state == ST_WAIT) & data_data_ok & r_isLoad) ? w_ldData :
                  ((r_state == ST_DONE) & r_isLoad)                ? r_held : 32'd0;

  assign mem_stall = rst & (((r_state == ST_IDLE)  & w_issuable) |
                            w_inReq |
                            ((r_state == ST_WAIT)  & ~data_data_ok) |
                            ((r_state == ST_DRAIN) & w_issuable));

  // Handshake FSM: issue, hold until accepted, wait for data, hold result while
  // the pipe is stalled elsewhere, or drain a response belonging to a flushed op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= 32'd0;
      r_wr        <= 1'b0;
      r_size      <= SIZE_BYTE;
      r_wdata     <= 32'd0;
      r_wstrb     <= 4'd0;
      r_op        <= 6'd0;
      r_isLoad    <= 1'b0;
      r_flushSeen <= 1'b0;
      r_held      <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issuable) begin
            r_addr      <= aluoutM;
            r_wr        <= mem_writeM;
            r_size      <= w_size;
            r_wdata     <= w_wdata;
            r_wstrb     <= w_wstrb;
            r_op        <= w_op;
            r_isLoad    <= mem_readM;
            r_flushSeen <= 1'b0;
            r_state     <= data_addr_ok ? ST_WAIT : ST_REQ;
          end
        end
        ST_REQ: begin
          if (flushM) r_flushSeen <= 1'b1;
          if (data_addr_ok) r_state <= (r_flushSeen | flushM) ? ST_DRAIN : ST_WAIT;
        end
        ST_WAIT: begin
          if (data_data_ok) begin
            r_held  <= r_isLoad ? w_ldData : 32'd0;
            r_state <= stall_ext ? ST_DONE : ST_IDLE;
          end else if (flushM) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          if (!stall_ext || flushM) r_state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (data_data_ok) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_mem_access_unit
// Brief    : Self-checking bench for mem_access_unit with a behavioural
//            memory-slave and expected-value model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        mem_readM, mem_writeM, except_blockM, flushM, stall_ext;
  logic [31:0] instrM, aluoutM, rt_valueM;
  logic        data_req, data_wr, data_uncached;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata, rdataM, badvaddrM;
  logic        adelM, adesM, mem_stall;

  int nCompared = 0;
  int nMismatched = 0;

  logic [5:0] opTable [8] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h28, 6'h29, 6'h2B};

  mem_access_unit #(.KSEG1_UNCACHED(1)) dut (
    .clk(clk), .rst(rst),
    .mem_readM(mem_readM), .mem_writeM(mem_writeM), .instrM(instrM),
    .aluoutM(aluoutM), .rt_valueM(rt_valueM), .except_blockM(except_blockM),
    .flushM(flushM), .stall_ext(stall_ext),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_uncached(data_uncached), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .rdataM(rdataM), .adelM(adelM), .adesM(adesM), .badvaddrM(badvaddrM),
    .mem_stall(mem_stall)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic driveOp(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt);
    logic [31:0] rnd;
    rnd        = $urandom;
    mem_readM  = (op[3] == 1'b0);
    mem_writeM = (op[3] == 1'b1);
    instrM     = {op, rnd[25:0]};
    aluoutM    = addr;
    rt_valueM  = rt;
  endtask

  task automatic idleCycle();
    @(negedge clk);
    mem_readM = 0; mem_writeM = 0; flushM = 0; stall_ext = 0; except_blockM = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = $urandom;
    #1;
    check("idle_req", {31'd0, data_req}, 32'd0);
    check("idle_rdata", rdataM, 32'd0);
  endtask

  // One M-stage load/store against a slave that accepts after aok cycles and
  // answers dok cycles later; expectations come from the ISA byte-lane rules.
  task automatic doOp(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                      input logic [31:0] rdata, input int aok, input int dok, input logic stx);
    logic        isLoad;
    int          sz, stalls, k;
    logic        misal, done;
    logic [31:0] expW, expD, shifted, expLd;
    logic [3:0]  expS;
    isLoad = (op[3] == 1'b0);
    sz     = (op[1:0] == 2'b11) ? 2 : (op[1:0] == 2'b01) ? 1 : 0;
    misal  = (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00);
    expS   = (sz == 0) ? (4'd1 << addr[1:0]) : (sz == 1) ? (addr[1] ? 4'hC : 4'h3) : 4'hF;
    expD   = (sz == 0) ? rt[7:0] * 32'h0101_0101 : (sz == 1) ? rt[15:0] * 32'h0001_0001 : rt;
    if (sz == 0) begin
      shifted = (rdata >> (8 * addr[1:0])) & 32'hFF;
      expLd   = (op[2] == 1'b0 && shifted >= 32'h80) ? shifted + 32'hFFFF_FF00 : shifted;
    end else if (sz == 1) begin
      shifted = (rdata >> (16 * addr[1])) & 32'hFFFF;
      expLd   = (op[2] == 1'b0 && shifted >= 32'h8000) ? shifted + 32'hFFFF_0000 : shifted;
    end else begin
      expLd = rdata;
    end
    expW = isLoad ? expLd : 32'd0;

    @(negedge clk);
    driveOp(op, addr, rt);
    flushM = 0; except_blockM = 0; stall_ext = stx;
    if (misal) begin
      data_addr_ok = 0; data_data_ok = 0;
      #1;
      check("adel", {31'd0, adelM}, {31'd0, isLoad});
      check("ades", {31'd0, adesM}, {31'd0, !isLoad});
      check("badvaddr", badvaddrM, addr);
      check("misal_req", {31'd0, data_req}, 32'd0);
      check("misal_stall", {31'd0, mem_stall}, 32'd0);
      return;
    end
    stalls = 0; done = 0; k = 0;
    while (k < 20 && !done) begin
      if (k > 0) @(negedge clk);
      data_addr_ok = (k == aok);
      data_data_ok = (k == aok + dok);
      data_rdata   = (k == aok + dok) ? rdata : $urandom;
      #1;
      if (mem_stall) stalls++;
      if (k == 0) begin
        check("no_adel", {31'd0, adelM | adesM}, 32'd0);
        check("no_badv", badvaddrM, 32'd0);
      end
      if (k <= aok) begin
        check("req_held", {31'd0, data_req}, 32'd1);
        check("req_addr", data_addr, addr);
        if (k == aok) begin
          check("req_wr", {31'd0, data_wr}, {31'd0, !isLoad});
          check("req_size", {30'd0, data_size}, sz);
          check("req_unc", {31'd0, data_uncached}, {31'd0, (addr >> 29) == 32'd5});
          if (!isLoad) begin
            check("req_wstrb", {28'd0, data_wstrb}, {28'd0, expS});
            check("req_wdata", data_wdata, expD);
          end
        end
      end else begin
        check("req_drop", {31'd0, data_req}, 32'd0);
      end
      if (k == aok + dok) begin
        check("rdataM", rdataM, expW);
        done = 1;
      end
      k++;
    end
    check("op_cycles", k, aok + dok + 1);
    check("stall_cnt", stalls, aok + dok);
    if (stx) begin
      @(negedge clk);
      data_addr_ok = 0; data_data_ok = 0; data_rdata = $urandom; stall_ext = 0;
      #1;
      check("done_rdata", rdataM, expW);
      check("done_stall", {31'd0, mem_stall}, 32'd0);
      check("done_req", {31'd0, data_req}, 32'd0);
    end
  endtask

  initial begin
    rst = 0; mem_readM = 1; mem_writeM = 0; instrM = {6'h23, 26'd0};
    aluoutM = 32'h6; rt_valueM = 0; except_blockM = 0; flushM = 0; stall_ext = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", {31'd0, data_req}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_adel", {31'd0, adelM}, 32'd0);
    check("rst_badv", badvaddrM, 32'd0);
    check("rst_rdata", rdataM, 32'd0);
    @(negedge clk);
    mem_readM = 0; rst = 1;
    idleCycle();

    // Directed cases
    doOp(6'h23, 32'h8000_0010, 32'd0, 32'hDEAD_BEEF, 0, 1, 0);
    idleCycle();
    doOp(6'h20, 32'h0000_0003, 32'd0, 32'h80FF_FF7F, 0, 1, 0);
    doOp(6'h24, 32'h0000_0003, 32'd0, 32'h80FF_FF7F, 1, 2, 0);
    doOp(6'h29, 32'h0000_0002, 32'h1234_5678, 32'd0, 0, 1, 0);
    doOp(6'h23, 32'h0000_0006, 32'd0, 32'd0, 0, 1, 0);
    idleCycle();
    doOp(6'h21, 32'hA000_0102, 32'd0, 32'hC3A5_5A3C, 2, 1, 1);
    idleCycle();

    // Flush while the request waits for addr_ok: request stays frozen, the
    // late response is drained, and the next load only issues afterwards.
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k == 0) begin
        driveOp(6'h23, 32'h0000_0040, 32'd0);
        stall_ext = 0; except_blockM = 0;
      end
      if (k == 2) driveOp(6'h23, 32'h0000_0080, 32'd0);
      flushM       = (k == 1);
      data_addr_ok = (k == 3) || (k == 6);
      data_data_ok = (k == 5) || (k == 7);
      data_rdata   = (k == 5) ? 32'hBAD0_BAD0 : 32'h1357_2468;
      #1;
      if (k <= 3) begin
        check("fl_req", {31'd0, data_req}, 32'd1);
        check("fl_addr", data_addr, 32'h0000_0040);
      end else if (k <= 5) begin
        check("drain_req", {31'd0, data_req}, 32'd0);
        check("drain_stall", {31'd0, mem_stall}, 32'd1);
        check("drain_rdata", rdataM, 32'd0);
      end else if (k == 6) begin
        check("post_req", {31'd0, data_req}, 32'd1);
        check("post_addr", data_addr, 32'h0000_0080);
      end else begin
        check("post_rdata", rdataM, 32'h1357_2468);
        check("post_stall", {31'd0, mem_stall}, 32'd0);
      end
    end
    idleCycle();

    // Asynchronous reset in the middle of WAIT
    @(negedge clk);
    driveOp(6'h23, 32'h0000_0100, 32'd0);
    data_addr_ok = 1;
    #1 check("ar_issue", {31'd0, data_req}, 32'd1);
    @(negedge clk);
    data_addr_ok = 0;
    #1 check("ar_wait_stall", {31'd0, mem_stall}, 32'd1);
    #1 rst = 0;
    #1;
    check("ar_req", {31'd0, data_req}, 32'd0);
    check("ar_stall", {31'd0, mem_stall}, 32'd0);
    check("ar_rdata", rdataM, 32'd0);
    @(negedge clk);
    rst = 1; data_addr_ok = 1;
    #1 check("ar_idle_req", {31'd0, data_req}, 32'd1);
    @(negedge clk);
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h55AA_1234;
    #1 check("ar_rdata2", rdataM, 32'h55AA_1234);
    idleCycle();

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a[31:29] = 3'b101;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      doOp(opTable[$urandom_range(0, 7)], a, $urandom, $urandom,
           $urandom_range(0, 3), $urandom_range(1, 3), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 0) idleCycle();
    end
    idleCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: KSEG1_UNCACHED, default 1, meaning: when 1, data_uncached=1 for addresses with addr[31:29]=3'b101; when 0, data_uncached is tied 0.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk in 1: single clock, all state on posedge.
- rst in 1: reset, asynchronous, active-low.
- mem_readM in 1: load present in M.
- mem_writeM in 1: store present in M.
- instrM in 32: opcode [31:26] selects lb/lbu/lh/lhu/lw/sb/sh/sw.
- aluoutM in 32: effective address.
- rt_valueM in 32: store data.
- except_blockM in 1: M instruction already carries an exception (ri/break/syscall/eret/overflow).
- flushM in 1: M stage flushed this cycle.
- stall_ext in 1: stall from sources other than this block.
- data_req out 1: request.
- data_wr out 1: 1 = store.
- data_size out 2: 0 byte, 1 half, 2 word.
- data_addr out 32: request address.
- data_wdata out 32: store data.
- data_wstrb out 4: byte enables.
- data_uncached out 1: uncached attribute.
- data_addr_ok in 1: address accepted.
- data_data_ok in 1: one-cycle pulse, data/ack return.
- data_rdata in 32: raw read word.
- rdataM out 32: aligned, extended load result.
- adelM out 1: load address error.
- adesM out 1: store address error.
- badvaddrM out 32: faulting address.
- mem_stall out 1: stall request to hazard unit.

Function
REQ-003 Misalignment: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0, SHALL raise adelM (load) or adesM (store) combinationally, set badvaddrM=aluoutM (else 0), and issue no request.
REQ-004 An op is issuable when (mem_readM|mem_writeM) & ~except_blockM & ~adelM & ~adesM & ~flushM.
REQ-005 FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
REQ-006 IDLE: data_req=1 combinationally when issuable; addr_ok=1 -> WAIT, addr_ok=0 -> REQ.
REQ-007 REQ: data_req held 1 with data_addr/wr/size/wdata/wstrb stable until addr_ok; then -> WAIT (-> DRAIN if flushM was seen while in REQ or on the exit cycle).
REQ-008 WAIT: on data_ok, load result is data_rdata aligned; stall_ext=1 -> DONE, else -> IDLE; flushM without data_ok -> DRAIN.
REQ-009 DONE: rdataM driven from a register captured at data_ok; no new request; -> IDLE when stall_ext=0 or flushM=1.
REQ-010 DRAIN: data_req=0; on data_ok discard data and go -> IDLE; a new issuable op waits.
REQ-011 A request withdrawn before addr_ok is forbidden; at most one outstanding request.
REQ-012 mem_stall=1 when an issuable op is not yet complete (IDLE/REQ, or WAIT without data_ok), or in DRAIN with a new issuable op; 0 in DONE and in the data_ok cycle.
REQ-013 Minimum latency: addr_ok in issue cycle plus data_ok next cycle gives 1 stall cycle.
REQ-014 Stores: sb wstrb=1<<addr[1:0], wdata={4{rt[7:0]}}; sh wstrb=addr[1]?4'b1100:4'b0011, wdata={2{rt[15:0]}}; sw wstrb=4'hF.
REQ-015 Loads: byte selected by addr[1:0], half by addr[1]; lb/lh sign-extend; lbu/lhu zero-extend; lw pass-through.
REQ-016 data_addr=aluoutM (physical mapping is not this block's job); data_size per REQ-002.
REQ-017 rdataM=0 for non-loads.

Reset
REQ-018 rst=0 SHALL immediately force IDLE, data_req=0, mem_stall=0, held rdata register=0, regardless of an in-flight request.
REQ-019 All combinational outputs SHALL be 0 while in reset.

Structure
REQ-020 Opcode constants (OP_LB..OP_SW), size encodings and FSM state encodings SHALL live in the shared CPU defines package.
REQ-021 One sub-module SHALL hold load/store alignment logic (REQ-014/015): mem_align, purely combinational.

Verification
REQ-022 lw at 0x8000_0010, addr_ok same cycle, data_ok next cycle with 0xDEAD_BEEF -> rdataM=0xDEADBEEF, mem_stall high exactly 1 cycle.
REQ-023 lb at 0x0000_0003, rdata 0x80FF_FF7F -> rdataM=0xFFFF_FF80; lbu -> 0x0000_0080.
REQ-024 sh at 0x0000_0002, rt=0x1234_5678 -> wstrb=4'b1100, wdata=0x5678_5678, size=1, wr=1.
REQ-025 lw at 0x0000_0006 -> adelM=1, badvaddrM=0x0000_0006, data_req never asserts.
REQ-026 addr_ok delayed 3 cycles with flushM pulsed in REQ -> req held stable until addr_ok, then DRAIN, data_ok data discarded, next load issues only after the drain.
REQ-027 Async rst=0 asserted mid-WAIT -> data_req=0 and IDLE immediately, without waiting for a clock edge.
